// File: rtl/psram_pkg.sv
// psram_pkg: shared constants, FSM states and byte-swap helper for psram_quad_xfer.
package psram_pkg;
   localparam logic [7:0] CMD_QREAD = 8'hEB;
   localparam logic [7:0] CMD_QWRITE = 8'h38;
   localparam int CMD_CYCLES = 8;
   localparam int ADDR_CYCLES = 6;
   localparam int DUMMY_CYCLES = 6;
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, STOP, GAP} state_t;
   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction
endpackage

// File: rtl/psram_nibble_shifter.sv
// psram_nibble_shifter: loadable 32-bit shifter, 1 or 4 bits out per step, 4 bits in per sample.
module psram_nibble_shifter (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        shift1,
   input  logic        shift4,
   input  logic        shin,
   input  logic [3:0]  din,
   output logic [31:0] q
);
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (load) q <= load_val;
      else if (shift1) q <= {q[30:0], 1'b0};
      else if (shift4) q <= {q[27:0], 4'h0};
      else if (shin) q <= {q[27:0], din};
endmodule

// File: rtl/psram_quad_xfer.sv
// psram_quad_xfer: Quad-I/O PSRAM burst engine (0xEB quad read / 0x38 quad write, 1-4 bytes).
// Define PSRAM_XFER_CE_GAP_EN to hold ce_n high for CE_GAP extra cycles before done.
module psram_quad_xfer import psram_pkg::*; #(
   parameter int CE_GAP = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        wr,
   input  logic [23:0] addr,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        sck,
   output logic        ce_n,
   output logic [3:0]  dout,
   output logic [3:0]  douten,
   input  logic [3:0]  din
);
`ifdef PSRAM_XFER_CE_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif
   state_t state, nxt;
   logic ph, active, sck_end, accept, load, shift1, shift4, shin, wr_r;
   logic [2:0] cnt, last;
   logic [1:0] size_r;
   logic [7:0] gcnt;
   logic [23:0] addr_r;
   logic [31:0] wdata_r, q, load_val;
   assign active = state inside {CMD, ADDR, DUMMY, RDATA, WDATA};
   assign last = state == CMD ? 3'(CMD_CYCLES - 1) : state == DUMMY ? 3'(DUMMY_CYCLES - 1) :
                 (state == RDATA || state == WDATA) ? {size_r, 1'b1} : 3'(ADDR_CYCLES - 1);
   assign sck_end = ph && cnt == last;
   assign done = GAP_EN ? state == GAP && gcnt == 8'(CE_GAP - 1) : state == STOP;
   assign busy = state != IDLE && !done;
   assign accept = start && !busy;
   assign ce_n = !active;
   assign sck = ph;
   assign douten = state == CMD ? 4'b0001 : (state == ADDR || state == WDATA) ? 4'b1111 : 4'b0000;
   assign dout = state == CMD ? {3'b000, q[31]} : (state == ADDR || state == WDATA) ? q[31:28] : 4'b0000;
   // Shifting happens at the end of the high phase so dout only moves while sck is low.
   assign load = accept || (sck_end && (state == CMD || (state == ADDR && wr_r)));
   assign load_val = accept ? {wr ? CMD_QWRITE : CMD_QREAD, 24'h0} : state == CMD ? {addr_r, 8'h00} : bswap(wdata_r);
   assign shift1 = ph && state == CMD;
   assign shift4 = ph && (state == ADDR || state == WDATA);
   assign shin = !ph && state == RDATA;
   psram_nibble_shifter u_shift (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val),
      .shift1(shift1), .shift4(shift4), .shin(shin), .din(din), .q(q)
   );
   always_comb begin
      nxt = state;
      if (accept) nxt = CMD;
      else if (state == STOP) nxt = GAP_EN ? GAP : IDLE;
      else if (done) nxt = IDLE;
      else if (sck_end)
         case (state)
            CMD: nxt = ADDR;
            ADDR: nxt = wr_r ? WDATA : DUMMY;
            DUMMY: nxt = RDATA;
            default: nxt = STOP;
         endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         ph <= 1'b0;
         cnt <= '0;
         gcnt <= '0;
         rdata <= '0;
         wr_r <= 1'b0;
         size_r <= '0;
         addr_r <= '0;
         wdata_r <= '0;
      end else begin
         state <= nxt;
         ph <= active && !ph;
         cnt <= (accept || sck_end) ? 3'd0 : cnt + 3'(ph);
         gcnt <= state == GAP ? gcnt + 8'd1 : 8'd0;
         if (accept) begin
            wr_r <= wr;
            size_r <= size;
            addr_r <= addr;
            wdata_r <= wdata;
            rdata <= '0;
         end
         // Bytes arrive first-byte-first in q's low 8N bits; left-align then swap to byte lanes.
         if (state == RDATA && sck_end) rdata <= bswap(q << {~size_r, 3'b000});
      end
endmodule

// File: tb/tb_psram_quad_xfer.sv
// tb_psram_quad_xfer: random and directed bursts against a behavioural PSRAM and a timeline model.
module tb_psram_quad_xfer;
`ifdef PSRAM_XFER_CE_GAP_EN
   localparam int G = 2;
`else
   localparam int G = 0;
`endif
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, wr = 1'b0;
   logic [23:0] addr = '0;
   logic [1:0] size = '0;
   logic [31:0] wdata = '0, rdata;
   logic busy, done, sck, ce_n;
   logic [3:0] dout, douten, din;
   int vc = 0, ec = 0, vl = 0, el = 0, cyc = 0;

   psram_quad_xfer dut (
      .clk(clk), .rst(rst), .start(start), .wr(wr), .addr(addr), .size(size), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .sck(sck), .ce_n(ce_n), .dout(dout),
      .douten(douten), .din(din)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] fill(input int i);
      return 8'(i * 37 + (i >> 7));
   endfunction

   // Behavioural PSRAM: samples on sck rise, presents read nibbles while sck is low.
   logic [7:0] mem [65536];
   logic [7:0] dcmd = '0;
   logic [23:0] daddr = '0;
   logic [15:0] wa, ra;
   int kc = 0;
   bit dinit = 1'b0;
   always @(posedge clk) begin
      if (!dinit) begin
         for (int i = 0; i < 65536; i++) mem[i] <= fill(i);
         dinit <= 1'b1;
      end
      if (ce_n) kc <= 0;
      else if (!sck) begin
         kc <= kc + 1;
         if (kc < 8) dcmd <= {dcmd[6:0], dout[0]};
         else if (kc < 14) daddr <= {daddr[19:0], dout};
         else if (dcmd == 8'h38) begin
            wa = 16'(daddr) + 16'((kc - 14) / 2);
            mem[wa] <= kc[0] ? {mem[wa][7:4], dout} : {dout, mem[wa][3:0]};
         end
      end
   end
   assign ra = 16'(daddr) + 16'((kc - 20) / 2);
   assign din = (dcmd == 8'hEB && kc >= 20) ? (kc[0] ? mem[ra][3:0] : mem[ra][7:4]) : 4'h0;

   // Transaction-level reference: accepted request, expected read bytes, reference memory.
   logic [7:0] ref_mem [65536];
   bit mi = 1'b0, m_on = 1'b0, m_wr = 1'b0, rd_valid = 1'b1;
   int m_t = 0, m_s = 0, m_n = 0;
   logic [23:0] m_a = '0;
   logic [31:0] m_d = '0, m_exp = '0, exp_rd = '0;
   always @(posedge clk) begin
      if (!mi) begin
         for (int i = 0; i < 65536; i++) ref_mem[i] = fill(i);
         mi = 1'b1;
      end
      if (rst) begin
         m_on = 1'b0;
         rd_valid = 1'b1;
         exp_rd = '0;
      end else begin
         if (m_on && !m_wr && cyc == m_t + 1 + 2 * m_s + G) begin
            rd_valid = 1'b1;
            exp_rd = m_exp;
         end
         if (start && !(m_on && cyc >= m_t + 1 && cyc <= m_t + 2 * m_s + G)) begin
            m_on = 1'b1; m_t = cyc; m_wr = wr; m_a = addr; m_d = wdata;
            m_n = int'(size) + 1;
            m_s = (wr ? 14 : 20) + 2 * m_n;
            m_exp = '0;
            rd_valid = 1'b0;
            for (int k = 0; k < m_n; k++)
               if (wr) ref_mem[16'(addr + 24'(k))] = wdata[8*k +: 8];
               else m_exp[8*k +: 8] = ref_mem[16'(addr + 24'(k))];
         end
      end
      cyc++;
   end

   // Per-cycle pin comparison against the expected transaction timeline.
   int i, j, d;
   bit act, eb, ed;
   logic [7:0] cmdb;
   logic [3:0] eoe, edo;
   logic [11:0] got, expv;
   always @(negedge clk) if (cyc > 0) begin
      act = m_on && cyc >= m_t + 1 && cyc <= m_t + 2 * m_s;
      eb = m_on && cyc >= m_t + 1 && cyc <= m_t + 2 * m_s + G;
      ed = m_on && cyc == m_t + 1 + 2 * m_s + G;
      i = cyc - m_t - 1;
      j = i / 2;
      cmdb = m_wr ? 8'h38 : 8'hEB;
      eoe = 4'h0;
      edo = 4'h0;
      if (act) begin
         if (j < 8) begin eoe = 4'h1; edo = {3'b000, cmdb[7-j]}; end
         else if (j < 14) begin eoe = 4'hF; edo = 4'(m_a >> (20 - 4 * (j - 8))); end
         else if (m_wr) begin d = j - 14; eoe = 4'hF; edo = 4'(m_d >> (8 * (d / 2) + ((d % 2) == 1 ? 0 : 4))); end
      end
      got = {ce_n, sck, busy, done, douten, dout & eoe};
      expv = {!act, act && (i % 2) == 1, eb, ed, eoe, edo};
      vc++;
      if (got !== expv) begin
         ec++;
         $display("FAIL pins cyc=%0d {ce_n,sck,busy,done,oe,dout} got=%h exp=%h", cyc, got, expv);
      end
      if (ed && !m_wr) begin
         vc++;
         if (rdata !== m_exp) begin ec++; $display("FAIL rdata_done cyc=%0d got=%h exp=%h", cyc, rdata, m_exp); end
      end else if (rd_valid && !eb && !ed) begin
         vc++;
         if (rdata !== exp_rd) begin ec++; $display("FAIL rdata_hold cyc=%0d got=%h exp=%h", cyc, rdata, exp_rd); end
      end
   end

   task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
      vl++;
      if (g !== e) begin el++; $display("FAIL %s got=%h exp=%h", nm, g, e); end
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done) begin dc = cyc; break; end
      end
      if (dc < 0) begin vl++; el++; $display("FAIL done_timeout got=none exp=pulse"); end
   endtask

   task automatic issue(input bit w, input logic [23:0] a, input logic [1:0] s, input logic [31:0] dd);
      start = 1'b1; wr = w; addr = a; size = s; wdata = dd;
      @(negedge clk);
      start = 1'b0; wr = 1'($urandom); addr = 24'($urandom); size = 2'($urandom); wdata = $urandom;
   endtask

   task automatic xfer(input bit w, input logic [23:0] a, input logic [1:0] s, input logic [31:0] dd, output int lat);
      int t, dc;
      t = cyc;
      issue(w, a, s, dd);
      wait_done(dc);
      lat = dc - t;
   endtask

   initial begin
      int lat, pulses, t, dc;
      bit w;
      logic [23:0] a;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_ce_n", 32'(ce_n), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rdata", rdata, 0);
      xfer(1'b1, 24'h000010, 2'd3, 32'hDDCCBBAA, lat);
      chk("wr4_lat", lat, 45 + G);
      chk("wr4_mem", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'hDDCCBBAA);
      xfer(1'b0, 24'h000010, 2'd3, 32'h0, lat);
      chk("rd4_lat", lat, 57 + G);
      chk("rd4_data", rdata, 32'hDDCCBBAA);
      xfer(1'b0, 24'h000012, 2'd0, 32'h0, lat);
      chk("rd1_lat", lat, 45 + G);
      chk("rd1_data", rdata, 32'h000000CC);
      issue(1'b0, 24'h000010, 2'd3, 32'h0);
      repeat (18) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_pins", {29'h0, ce_n, sck, busy}, 32'h4);
      pulses = 0;
      repeat (70) begin @(negedge clk); if (done) pulses++; end
      chk("abort_done", pulses, 0);
      xfer(1'b0, 24'h000010, 2'd3, 32'h0, lat);
      chk("post_abort_rd", rdata, 32'hDDCCBBAA);
      t = cyc;
      issue(1'b0, 24'h000010, 2'd3, 32'h0);
      repeat (5) @(negedge clk);
      issue(1'b1, 24'h000555, 2'd3, 32'h12345678);
      wait_done(dc);
      chk("ign_lat", dc - t, 57 + G);
      chk("ign_data", rdata, 32'hDDCCBBAA);
      chk("ign_mem", 32'(mem[16'h555]), 32'(fill(16'h555)));
      t = cyc;
      issue(1'b1, 24'h001FFF, 2'd1, 32'h00005A3C);
      chk("b2b_ce_n", 32'(ce_n), 0);
      wait_done(dc);
      chk("b2b_lat", dc - t, 37 + G);
      chk("wrap_mem", {mem[16'h2000], mem[16'h1FFF]}, 32'h5A3C);
      xfer(1'b0, 24'h001FFF, 2'd1, 32'h0, lat);
      chk("wrap_rd", rdata, 32'h00005A3C);
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         w = 1'($urandom);
         a = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h000100 + 24'($urandom_range(0, 15));
         xfer(w, a, 2'($urandom), $urandom, lat);
      end
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vc + vl, ec + el);
      $finish;
   end
endmodule
